// File: rtl/mem_loader_if.sv
// mem_loader_if: bundles the control, byte-stream and memory-port signals
// of the memory loader.
//   control : start, base_addr, word_count -> loader; busy, done, error <- loader
//   stream  : in_data, in_valid -> loader; in_ready <- loader
//   memory  : mem_addr, mem_wdata, mem_we <- loader; mem_rdata -> loader
// Modports: master = the loader itself, slave = whatever drives/observes it.
interface mem_loader_if #(
    parameter int AW = 16,
    parameter int CW = 13
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic          busy;
    logic          done;
    logic          error;

    modport master (
        input  start, base_addr, word_count, in_data, in_valid, mem_rdata,
        output in_ready, mem_addr, mem_wdata, mem_we, busy, done, error
    );

    modport slave (
        output start, base_addr, word_count, in_data, in_valid, mem_rdata,
        input  in_ready, mem_addr, mem_wdata, mem_we, busy, done, error
    );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: reloads a DEPTH x 32 memory from a byte stream. Bytes are
// packed most-significant first into 32-bit words; word_count words are
// written starting at base_addr.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - mem_loader_if.master (control, byte stream, memory port)
// Optional build macro: MEM_LOADER_VERIFY_EN adds a read-back CHECK cycle
// after every write; a mismatch sets error and aborts the load.
//
// state | meaning
// IDLE  | waiting for start
// RECV  | collecting 4 bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// CHECK | read-back compare of the word just written (verify build only)
// DONE  | one-cycle done pulse, back to IDLE
module mem_loader #(
    parameter int DEPTH = 4096,
    parameter int AW    = 16,
    parameter int CW    = 13
) (
    input logic         clk,
    input logic         reset,
    mem_loader_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] remain_q;
    logic [1:0]    byte_cnt_q;
    logic [31:0]   word_q;
    logic          error_q;

    logic in_ready_c, mem_we_c, busy_c, done_c;
    logic latch_c, accept_c, advance_c, set_err_c;

    logic [AW-1:0] addr_inc;
    state_t        post_state;
    logic          post_err;

    assign addr_inc = addr_q + AW'(1);

    // Outcome of finishing a word: stop on the last word, abort when the
    // next address falls off the end of memory (no wrap-around).
    always_comb begin
        post_state = RECV;
        post_err   = 1'b0;
        if (remain_q == CW'(1)) begin
            post_state = DONE;
        end else if (addr_inc == DEPTH_A) begin
            post_state = DONE;
            post_err   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        mem_we_c   = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        latch_c    = 1'b0;
        accept_c   = 1'b0;
        advance_c  = 1'b0;
        set_err_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    latch_c = 1'b1;
                    if (bus.word_count == '0) begin
                        state_d = DONE;
                    end else if (bus.base_addr >= DEPTH_A) begin
                        set_err_c = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                busy_c     = 1'b1;
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept_c = 1'b1;
                    if (byte_cnt_q == 2'd3) state_d = WRITE;
                end
            end
            WRITE: begin
                busy_c   = 1'b1;
                mem_we_c = 1'b1;
`ifdef MEM_LOADER_VERIFY_EN
                state_d = CHECK;
`else
                advance_c = 1'b1;
                set_err_c = post_err;
                state_d   = post_state;
`endif
            end
`ifdef MEM_LOADER_VERIFY_EN
            CHECK: begin
                busy_c = 1'b1;
                if (bus.mem_rdata != word_q) begin
                    set_err_c = 1'b1;
                    state_d   = DONE;
                end else begin
                    advance_c = 1'b1;
                    set_err_c = post_err;
                    state_d   = post_state;
                end
            end
`endif
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath. Bytes shift in from the bottom so the first byte ends up in
    // bits [31:24] after four accepts; the byte counter wraps on its own.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            remain_q   <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            if (latch_c) begin
                addr_q     <= bus.base_addr;
                remain_q   <= bus.word_count;
                byte_cnt_q <= '0;
            end
            if (accept_c) begin
                word_q     <= {word_q[23:0], bus.in_data};
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
            if (advance_c) begin
                addr_q   <= addr_inc;
                remain_q <= remain_q - CW'(1);
            end
            // An out-of-range start sets error in the same cycle it clears it.
            if (set_err_c)    error_q <= 1'b1;
            else if (latch_c) error_q <= 1'b0;
        end
    end

`ifndef MEM_LOADER_VERIFY_EN
    logic [31:0] unused_rdata;
    assign unused_rdata = bus.mem_rdata;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.error     = error_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = word_q;
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed and randomized loads against a reference model
// that predicts the list of memory writes, the error flag and the latency
// directly from base/count/byte stream.
module tb_mem_loader;
`ifdef MEM_LOADER_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_loader_if bus ();
    mem_loader dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] mem [0:4095];
    bit          corrupt_rd = 1'b0;
    assign bus.mem_rdata = corrupt_rd ? 32'h0 : mem[bus.mem_addr[11:0]];

    logic [47:0] wq[$];
    bit          ready_bad;
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wq.push_back({bus.mem_addr, bus.mem_wdata});
            mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
            if (bus.in_ready !== 1'b0) ready_bad = 1'b1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  bytes[$];
    logic [47:0] exp_w[$];
    bit          exp_err;
    int          exp_lat;

    // Reference: which words land where, whether the load errors, and how
    // long an unstalled load takes from start to done.
    task automatic predict(input int base, input int cnt, input bit corrupt);
        exp_w.delete();
        exp_err = 1'b0;
        if (cnt != 0) begin
            if (base >= 4096) exp_err = 1'b1;
            else begin
                for (int i = 0; i < cnt; i++) begin
                    int a;
                    logic [31:0] w;
                    a = base + i;
                    if (a >= 4096) begin
                        exp_err = 1'b1;
                        break;
                    end
                    w = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
                    exp_w.push_back({16'(a), w});
                    if (VERIFY_ON && corrupt && w != 32'h0) begin
                        exp_err = 1'b1;
                        break;
                    end
                end
            end
        end
        exp_lat = 1 + (VERIFY_ON ? 6 : 5) * exp_w.size();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ":in_ready"}, bus.in_ready, 0);
        check({tag, ":mem_we"}, bus.mem_we, 0);
        check({tag, ":busy"}, bus.busy, 0);
        check({tag, ":done"}, bus.done, 0);
        check({tag, ":error"}, bus.error, 0);
        check({tag, ":mem_addr"}, bus.mem_addr, 0);
        check({tag, ":mem_wdata"}, bus.mem_wdata, 0);
    endtask

    // stall_mode: 0 = in_valid always, 1 = every other cycle, 2 = random.
    // inject_at: cycle (after start) at which a stray start is pulsed.
    // abort_bytes: return once this many bytes were accepted (0 = run to done).
    task automatic load(input int base, input int cnt, input int stall_mode,
                        input bit corrupt, input int inject_at,
                        input int abort_bytes, input string tag);
        int idx;
        int lat;
        bit got_done;
        bit acc;
        bit v;
        idx = 0;
        got_done = 1'b0;
        predict(base, cnt, corrupt);
        wq.delete();
        ready_bad = 1'b0;
        corrupt_rd = corrupt;
        bus.base_addr = 16'(base);
        bus.word_count = 13'(cnt);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.base_addr = 16'($urandom);
        bus.word_count = 13'($urandom);
        lat = 1;
        check({tag, ":busy_after_start"}, bus.busy, (cnt != 0 && base < 4096));
        while (!got_done && lat < 2000) begin
            if (bus.done === 1'b1) got_done = 1'b1;
            else begin
                if (abort_bytes != 0 && idx == abort_bytes) return;
                bus.start = (lat == inject_at);
                if (lat == inject_at) begin
                    bus.base_addr = 16'h0200;
                    bus.word_count = 13'd1;
                end
                case (stall_mode)
                    0:       v = 1'b1;
                    1:       v = lat[0];
                    default: v = 1'($urandom_range(0, 1));
                endcase
                bus.in_valid = v && (idx < bytes.size());
                bus.in_data = (idx < bytes.size()) ? bytes[idx] : 8'h00;
                acc = bus.in_valid && bus.in_ready;
                @(posedge clk);
                if (acc) idx++;
                @(negedge clk);
                lat++;
                bus.in_valid = 1'b0;
                bus.start = 1'b0;
            end
        end
        check({tag, ":done_seen"}, got_done, 1);
        if (stall_mode == 0) check({tag, ":latency"}, lat, exp_lat);
        check({tag, ":error"}, bus.error, exp_err);
        check({tag, ":n_writes"}, wq.size(), exp_w.size());
        for (int i = 0; i < wq.size() && i < exp_w.size(); i++)
            check({tag, ":write"}, wq[i], exp_w[i]);
        check({tag, ":bytes_taken"}, idx, 4 * exp_w.size());
        check({tag, ":ready_in_write"}, ready_bad, 0);
        @(negedge clk);
        check({tag, ":done_one_cycle"}, bus.done, 0);
        check({tag, ":idle_busy"}, bus.busy, 0);
        corrupt_rd = 1'b0;
    endtask

    task automatic rand_bytes(input int n);
        bytes.delete();
        for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_count = '0;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load(16'h0010, 1, 0, 1'b0, -1, 0, "single");

        bytes.delete();
        for (int i = 0; i < 12; i++) bytes.push_back(8'(i));
        load(16'h0100, 3, 1, 1'b0, -1, 0, "burst");

        bytes.delete();
        load(16'h0040, 0, 0, 1'b0, -1, 0, "count0");

        rand_bytes(8);
        load(16'h0FFF, 2, 0, 1'b0, -1, 0, "top_edge");

        rand_bytes(4);
        load(16'h1000, 1, 0, 1'b0, -1, 0, "base_oob");

        rand_bytes(16);
        load(16'h0300, 4, 0, 1'b0, -1, 6, "rst_mid");
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst_mid");
        reset = 1'b0;
        check("rst_mid:n_writes", wq.size(), 1);
        check("rst_mid:first_word", wq[0], {16'h0300, bytes[0], bytes[1], bytes[2], bytes[3]});
        @(negedge clk);
        load(16'h0300, 4, 0, 1'b0, -1, 0, "rst_reload");

        rand_bytes(8);
        load(16'h0050, 2, 0, 1'b0, 3, 0, "start_busy");

        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        load(16'h0020, 2, 0, 1'b1, -1, 0, "verify_bad");

        for (int r = 0; r < 6; r++) begin
            int base;
            int cnt;
            cnt = $urandom_range(1, 5);
            base = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4095)
                                               : 4096 - $urandom_range(1, 3);
            rand_bytes(4 * cnt);
            load(base, cnt, $urandom_range(0, 2), 1'b0, -1, 0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
